// File: rtl/clk_enable_gen_if.sv
// Bundles the control and output signals of clk_enable_gen.
// clk and rst_n are kept out of the bundle.
interface clk_enable_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 27,
  parameter int TB_W   = 32
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*DIV_W-1:0] div_in;
  logic                    sync_clr;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       level;
  logic [TB_W-1:0]         tb_cnt;

  modport master (
    output en, load, div_in, sync_clr,
    input  tick, level, tb_cnt
  );

  modport slave (
    input  en, load, div_in, sync_clr,
    output tick, level, tb_cnt
  );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: each channel has a programmable divisor and
// produces a one-cycle tick and a level that toggles on every tick. Also has a free-running timebase.
module clk_enable_ch #(
  parameter int DIV_W   = 27,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             sync_clr,
  output logic             tick,
  output logic             level
);
  localparam logic [DIV_W-1:0] DIV_RST = (DEF_DIV == 0) ? DIV_W'(1) : DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic             wrap;

  // div is never 0, so div-1 cannot underflow and cnt stays within div-1
  assign wrap = (cnt == div - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div   <= DIV_RST;
      tick  <= 1'b0;
      level <= 1'b0;
    end else begin
      if (load) div <= (div_in == '0) ? DIV_W'(1) : div_in;
      if (sync_clr) begin
        cnt   <= '0;
        tick  <= 1'b0;
        level <= 1'b0;
      end else if (load) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (en) begin
        if (wrap) begin
          cnt   <= '0;
          tick  <= 1'b1;
          level <= ~level;
        end else begin
          cnt  <= cnt + DIV_W'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end
endmodule

module clk_enable_gen #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 27,
  parameter int DEF_DIV = 4,
  parameter int TB_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  clk_enable_gen_if.slave bus
);
  logic [NUM_CH-1:0][DIV_W-1:0] div_arr;
  logic [NUM_CH-1:0]            tick_w;
  logic [NUM_CH-1:0]            level_w;
  logic [TB_W-1:0]              tb_q;

  assign div_arr = bus.div_in;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_enable_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en[i]),
      .load     (bus.load[i]),
      .div_in   (div_arr[i]),
      .sync_clr (bus.sync_clr),
      .tick     (tick_w[i]),
      .level    (level_w[i])
    );
  end

  // Timebase deliberately ignores sync_clr so it stays monotonic across realigns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_q <= '0;
    else        tb_q <= tb_q + TB_W'(1);
  end

  assign bus.tick   = tick_w;
  assign bus.level  = level_w;
  assign bus.tb_cnt = tb_q;
endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: 4 channels, narrow timebase so its wrap is reachable.
module tb_clk_enable_gen;
  localparam int NC = 4;
  localparam int DW = 27;
  localparam int TW = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  clk_enable_gen_if #(.NUM_CH(NC), .DIV_W(DW), .TB_W(TW)) bus ();

  clk_enable_gen #(.NUM_CH(NC), .DIV_W(DW), .DEF_DIV(4), .TB_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus.en = '0; bus.load = '0; bus.div_in = '0; bus.sync_clr = 1'b0;
    step(2);
    chk("rst_tick", bus.tick, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_tb", bus.tb_cnt, 0);

    // default divisor 4 on every channel
    bus.en = '1; rst_n = 1'b1;
    step(3); chk("d4_e3_tick", bus.tick, 0); chk("d4_e3_tb", bus.tb_cnt, 3);
    step(1); chk("d4_e4_tick", bus.tick, 4'hF); chk("d4_e4_level", bus.level, 4'hF);
    step(1); chk("d4_e5_tick", bus.tick, 0);
    step(3); chk("d4_e8_tick", bus.tick, 4'hF); chk("d4_e8_level", bus.level, 0);
    chk("d4_e8_tb", bus.tb_cnt, 8);

    // ch1 divisor 1
    clr();
    bus.load = 4'b0010; bus.div_in[1*DW +: DW] = 27'd1;
    step(1); bus.load = '0;
    chk("d1_l_tick", bus.tick, 0);
    step(1); chk("d1_1_tick", bus.tick, 4'b0010); chk("d1_1_level", bus.level, 4'b0010);
    step(1); chk("d1_2_tick", bus.tick, 4'b0010); chk("d1_2_level", bus.level, 4'b0000);
    step(1); chk("d1_3_tick", bus.tick, 4'hF);    chk("d1_3_level", bus.level, 4'hF);

    // ch2 divisor 0 behaves as 1
    clr();
    bus.load = 4'b0100; bus.div_in[2*DW +: DW] = 27'd0;
    step(1); bus.load = '0;
    step(1); chk("d0_1_tick", bus.tick, 4'b0110); chk("d0_1_level", bus.level, 4'b0100);
    step(1); chk("d0_2_tick", bus.tick, 4'b0110); chk("d0_2_level", bus.level, 4'b0010);
    step(1); chk("d0_3_tick", bus.tick, 4'hF);    chk("d0_3_level", bus.level, 4'b1101);

    // sync_clr with load on ch0 mid-period, level high beforehand
    clr();
    step(4); chk("sc_pre_level0", bus.level[0], 1);
    step(2);
    bus.sync_clr = 1'b1; bus.load = 4'b0001; bus.div_in[0*DW +: DW] = 27'd10;
    step(1); bus.sync_clr = 1'b0; bus.load = '0;
    chk("sc_level0", bus.level[0], 0);
    chk("sc_tick0", bus.tick[0], 0);
    for (int k = 1; k <= 9; k++) begin
      step(1); chk($sformatf("sc_gap%0d_tick0", k), bus.tick[0], 0);
    end
    step(1); chk("sc_d10_tick0", bus.tick[0], 1); chk("sc_d10_level0", bus.level[0], 1);

    // en[3] gap at cnt=1
    clr();
    step(1);
    bus.en[3] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1); chk($sformatf("gap%0d_tick3", k), bus.tick[3], 0);
    end
    bus.en[3] = 1'b1;
    step(2); chk("gap_r2_tick3", bus.tick[3], 0);
    step(1); chk("gap_r3_tick3", bus.tick[3], 1); chk("gap_r3_level3", bus.level[3], 1);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick", bus.tick, 0);
    chk("arst_level", bus.level, 0);
    chk("arst_tb", bus.tb_cnt, 0);
    rst_n = 1'b1;
    step(3); chk("arst_e3_tick", bus.tick, 0);
    step(1); chk("arst_e4_tick", bus.tick, 4'hF);
    chk("arst_e4_tb", bus.tb_cnt, 4);

    // timebase ignores sync_clr and wraps
    step(496);
    bus.sync_clr = 1'b1;
    step(1); bus.sync_clr = 1'b0;
    chk("tb_sclr", bus.tb_cnt, 501);
    step(522); chk("tb_max", bus.tb_cnt, 1023);
    step(1);   chk("tb_wrap", bus.tb_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
